// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm set-point keeper: state encoding and field limits.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2
    } ring_state_t;

    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int CNT_W   = 8;

endpackage

// File: rtl/alarm_time_keeper_mod_counter.sv
// Increment-with-wrap register: counts 0..MODULUS-1 on each inc pulse.
module mod_counter #(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= '0;
        else if (inc)
            value <= (value == WIDTH'(MODULUS - 1)) ? '0 : value + 1'b1;
    end

endmodule

// File: rtl/alarm_time_keeper.sv
// Alarm set-point registers plus the arm/ring/timeout state machine.
module alarm_time_keeper
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS = 60,
    parameter int HOUR_MOD     = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_sec,
    input  logic              up_min,
    input  logic              up_hour,
    input  logic              tick_1hz,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic              arm,
    input  logic              dismiss,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_min,
    output logic [SEC_W-1:0]  alarm_sec,
    output logic              ringing,
    output logic [1:0]        ring_state
);

    ring_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              match, match_q, match_rise;

    mod_counter #(.WIDTH(SEC_W), .MODULUS(SEC_MAX + 1)) u_sec (
        .clk(clk), .reset(reset), .inc(up_sec), .value(alarm_sec)
    );
    mod_counter #(.WIDTH(MIN_W), .MODULUS(MIN_MAX + 1)) u_min (
        .clk(clk), .reset(reset), .inc(up_min), .value(alarm_min)
    );
    mod_counter #(.WIDTH(HOUR_W), .MODULUS(HOUR_MOD)) u_hour (
        .clk(clk), .reset(reset), .inc(up_hour), .value(alarm_hour)
    );

    assign match      = (cur_hour == alarm_hour) && (cur_min == alarm_min) &&
                        (cur_sec == alarm_sec);
    assign match_rise = match && !match_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= match;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!arm) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (match_rise) begin
                        state_d = ST_RINGING;
                        cnt_d   = CNT_W'(RING_SECONDS);
                    end
                end
                ST_RINGING: begin
                    if (dismiss)
                        state_d = ST_ARMED;
                    else if (tick_1hz) begin
                        // The last remaining second ends the ring rather than reaching zero.
                        if (cnt_q == CNT_W'(1))
                            state_d = ST_ARMED;
                        else
                            cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ringing    = (state_q == ST_RINGING);
    assign ring_state = state_q;

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Directed scenarios plus randomized traffic against a behavioural alarm model.
module tb_alarm_time_keeper;

    localparam int RS = 3;
    localparam int HM = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up_sec = 0, up_min = 0, up_hour = 0, tick_1hz = 0, arm = 0, dismiss = 0;
    logic [4:0] cur_hour = 0;
    logic [5:0] cur_min = 0, cur_sec = 0;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min, alarm_sec;
    logic       ringing;
    logic [1:0] ring_state;

    int n_checks = 0;
    int n_pass   = 0;

    // model: set-point, mode (0 idle, 1 armed, 2 ringing), seconds of ring left, last match
    int m_h, m_m, m_s, m_mode, m_left;
    bit m_was_match;

    alarm_time_keeper #(.RING_SECONDS(RS), .HOUR_MOD(HM)) dut (
        .clk(clk), .reset(reset), .up_sec(up_sec), .up_min(up_min), .up_hour(up_hour),
        .tick_1hz(tick_1hz), .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .arm(arm), .dismiss(dismiss), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_sec(alarm_sec), .ringing(ringing), .ring_state(ring_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_left = 0; m_was_match = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit now_match;
        now_match = (int'(cur_hour) == m_h) && (int'(cur_min) == m_m) && (int'(cur_sec) == m_s);
        if (!arm) begin
            m_mode = 0; m_left = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (now_match && !m_was_match) begin m_mode = 2; m_left = RS; end
        end else begin
            if (dismiss) m_mode = 1;
            else if (tick_1hz) begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 1;
            end
        end
        m_was_match = now_match;
        if (up_sec)  m_s = (m_s + 1) % 60;
        if (up_min)  m_m = (m_m + 1) % 60;
        if (up_hour) m_h = (m_h + 1) % HM;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".hour"},  int'(alarm_hour), m_h);
        chk({tag, ".min"},   int'(alarm_min),  m_m);
        chk({tag, ".sec"},   int'(alarm_sec),  m_s);
        chk({tag, ".state"}, int'(ring_state), m_mode);
        chk({tag, ".ring"},  int'(ringing),    (m_mode == 2) ? 1 : 0);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk); #1;
        check_model(tag);
        up_sec = 0; up_min = 0; up_hour = 0; tick_1hz = 0; dismiss = 0;
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    task automatic pulses(input int nh, input int nm, input int ns);
        for (int i = 0; i < nh; i++) begin up_hour = 1; cycle("edit_h"); end
        for (int i = 0; i < nm; i++) begin up_min = 1; cycle("edit_m"); end
        for (int i = 0; i < ns; i++) begin up_sec = 1; cycle("edit_s"); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; #1;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset.state", int'(ring_state), 0);
        chk("reset.ring",  int'(ringing), 0);
        chk("reset.sec",   int'(alarm_sec), 0);
        @(negedge clk); reset = 0;

        // seconds wrap, hours wrap, simultaneous edits
        set_cur(23, 59, 58);
        pulses(0, 0, 61);
        chk("sec_wrap61", int'(alarm_sec), 1);
        chk("sec_wrap61.min", int'(alarm_min), 0);
        pulses(24, 0, 0);
        chk("hour_wrap24", int'(alarm_hour), 0);
        up_sec = 1; up_min = 1; up_hour = 1; cycle("simul");
        chk("simul.h", int'(alarm_hour), 1);
        chk("simul.m", int'(alarm_min), 1);
        chk("simul.s", int'(alarm_sec), 2);

        // basic ring at 07:30:00 and dismiss
        do_reset();
        pulses(7, 30, 0);
        arm = 1; set_cur(7, 29, 59); cycle("arm");
        chk("armed", int'(ring_state), 1);
        cycle("pre");
        set_cur(7, 30, 0); cycle("match");
        chk("match.ring", int'(ringing), 1);
        chk("match.state", int'(ring_state), 2);
        cycle("hold");
        dismiss = 1; cycle("dismiss");
        chk("dismiss.state", int'(ring_state), 1);
        for (int i = 0; i < 4; i++) cycle("no_rering");
        chk("no_rering.ring", int'(ringing), 0);

        // timeout after RS ticks
        set_cur(7, 30, 1); cycle("away");
        set_cur(7, 30, 0); cycle("rering");
        chk("rering.ring", int'(ringing), 1);
        tick_1hz = 1; cycle("tick1");
        tick_1hz = 1; cycle("tick2");
        chk("tick2.ring", int'(ringing), 1);
        tick_1hz = 1; cycle("tick3");
        chk("timeout.ring", int'(ringing), 0);
        chk("timeout.state", int'(ring_state), 1);

        // disarm mid-ring
        set_cur(7, 30, 1); cycle("away2");
        set_cur(7, 30, 0); cycle("ring3");
        chk("ring3.ring", int'(ringing), 1);
        arm = 0; cycle("disarm");
        chk("disarm.state", int'(ring_state), 0);

        // arming while already matching does not ring
        cycle("idle_match");
        arm = 1;
        for (int i = 0; i < 4; i++) cycle("arm_in_match");
        chk("arm_in_match.state", int'(ring_state), 1);

        // edit into equality: 07:30:00 -> 12:00:04, then bump sec to 5
        set_cur(12, 0, 5);
        pulses(5, 30, 4);
        chk("edit.h", int'(alarm_hour), 12);
        chk("edit.m", int'(alarm_min), 0);
        chk("edit.s", int'(alarm_sec), 4);
        up_sec = 1; cycle("edit_eq");
        chk("edit_eq.ring", int'(ringing), 0);
        cycle("edit_ring");
        chk("edit_ring.ring", int'(ringing), 1);

        // asynchronous reset between edges while ringing
        #3 reset = 1;
        #1;
        chk("async.ring",  int'(ringing), 0);
        chk("async.state", int'(ring_state), 0);
        chk("async.hour",  int'(alarm_hour), 0);
        chk("async.sec",   int'(alarm_sec), 0);
        model_reset();
        @(negedge clk); reset = 0;

        // randomized traffic, cur time often pinned to the set-point
        for (int i = 0; i < 3000; i++) begin
            arm      = ($urandom_range(0, 19) != 0);
            up_sec   = ($urandom_range(0, 7) == 0);
            up_min   = ($urandom_range(0, 9) == 0);
            up_hour  = ($urandom_range(0, 9) == 0);
            tick_1hz = ($urandom_range(0, 2) == 0);
            dismiss  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) set_cur(m_h, m_m, m_s);
            else if ($urandom_range(0, 1) == 0)
                set_cur(m_h, m_m, (m_s + 1) % 60);
            else
                set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
